microwave_timer_ctrl: RTL
=========================

MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 Parameter BEEP_TICKS, default 3: number of tick_1hz pulses for which done_beep stays high after countdown ends.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-005 key_valid  input  1  one-clk-wide pulse; key_digit valid this cycle.
REQ-006 key_digit  input  4  BCD keypad digit.
REQ-007 start  input  1  start/resume request, level sampled each clk.
REQ-008 stop_clr  input  1  stop/cancel request, level sampled each clk.
REQ-009 door_closed  input  1  1 = door closed.
REQ-010 zero_flags  input  4  zero outputs of the counters {m1,m0,s1,s0}; all_zero = &zero_flags.
REQ-011 load_n  output  1  active-low parallel load to all four digit counters.
REQ-012 load_data  output  16  {m1,m0,s1,s0} BCD load value = entry register.
REQ-013 count_en  output  1  enable to the seconds-units counter (borrow chain handled by counters).
REQ-014 mag_on  output  1  magnetron drive.
REQ-015 done_beep  output  1  end-of-cook indicator.
REQ-016 state  output  3  current FSM state encoding (IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4, DONE=5).

Function
REQ-017 FSM states SHALL be IDLE, ENTRY, LOAD, RUN, PAUSE, DONE; per-cycle request priority: stop_clr > start > key_valid.
REQ-018 key_valid with key_digit <= 9 in IDLE or ENTRY SHALL shift entry left 4 bits, insert digit at s0, discard old m1, go/stay ENTRY; key_digit > 9 SHALL be ignored.
REQ-019 key_valid in LOAD, RUN, PAUSE or DONE SHALL be ignored.
REQ-020 start in ENTRY SHALL go to LOAD only if door_closed=1, entry != 0 and s1 digit <= 5; otherwise state unchanged.
REQ-021 start in IDLE SHALL be ignored.
REQ-022 LOAD SHALL last exactly one cycle with load_n=0 and count_en=0, then go to RUN.
REQ-023 count_en SHALL equal (state==RUN) & tick_1hz & door_closed & !all_zero, combinationally.
REQ-024 RUN with all_zero=1 SHALL go to DONE next cycle; a coincident tick SHALL NOT produce count_en (no wrap to 9).
REQ-025 RUN with door_closed=0 SHALL go to PAUSE next cycle; count_en stays 0 meanwhile.
REQ-026 RUN with stop_clr=1 SHALL go to PAUSE; counters keep their value.
REQ-027 PAUSE with start=1 and door_closed=1 SHALL go to RUN without reloading; start with door open SHALL be ignored.
REQ-028 stop_clr in PAUSE, ENTRY or DONE SHALL go to IDLE and clear entry to 0; in IDLE it SHALL clear entry.
REQ-029 mag_on SHALL be 1 iff state==RUN and door_closed=1.
REQ-030 done_beep SHALL be 1 throughout DONE; DONE SHALL exit to IDLE after BEEP_TICKS tick_1hz pulses counted in DONE, entry cleared.
REQ-031 load_n SHALL be 1 in every state except LOAD.

Reset
REQ-032 clear=0 SHALL immediately force state=IDLE, entry=0, beep counter=0, load_n=1, count_en=0, mag_on=0, done_beep=0, regardless of clk.
REQ-033 Reset asserted in RUN or LOAD SHALL abort the cycle; no load pulse or count_en glitch after release; first post-release edge evaluates from IDLE.

Verification
REQ-034 Keys 1,3,0 then start, door closed -> load_data=16'h0130, one-cycle load_n=0, then RUN with mag_on=1; 90 ticks -> all_zero, DONE, done_beep for 3 ticks, then IDLE.
REQ-035 Keys 1,2,3,4,5 -> load_data=16'h2345; key 4'hB -> unchanged; keys 0,0,7,0 then start -> rejected (s1=7), state stays ENTRY.
REQ-036 RUN, door_closed dropped before tick -> PAUSE, mag_on=0, count_en=0 at tick; door closed + start -> RUN, counters continue from held value, load_n stays 1.
REQ-037 RUN with zero_flags=4'hF and tick_1hz same cycle -> count_en=0, next state DONE.
REQ-038 start and stop_clr asserted together in PAUSE -> IDLE, entry=0.
REQ-039 clear pulsed low mid-RUN between clk edges -> outputs reset immediately; after release, start ignored until new entry.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller: BCD time entry, load of external digit counters,
// run/pause countdown gating and end-of-cook beep timing.
module microwave_timer_ctrl #(
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        tick_1hz,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clr,
  input  logic        door_closed,
  input  logic [3:0]  zero_flags,
  output logic        load_n,
  output logic [15:0] load_data,
  output logic        count_en,
  output logic        mag_on,
  output logic        done_beep,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

  state_t         state_q, state_d;
  logic [15:0]    entry_q, entry_d;
  logic [BW-1:0]  beep_q, beep_d;

  logic           all_zero;
  logic           key_ok;
  logic           start_ok;
  logic [15:0]    entry_shift;

  // Handshake: key_valid is a single-cycle strobe qualifying key_digit; there is no
  // back-pressure, so a key arriving in a state that cannot use it is simply dropped.
  assign all_zero    = &zero_flags;
  assign key_ok      = key_valid && (key_digit <= 4'd9);
  assign entry_shift = {entry_q[11:0], key_digit};
  // Seconds-tens must be a legal 0..5 digit or the counters would count from an invalid time.
  assign start_ok    = door_closed && (entry_q != 16'h0000) && (entry_q[7:4] <= 4'd5);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      entry_q <= 16'h0000;
      beep_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      beep_q  <= beep_d;
    end
  end

  // Request priority inside each state: stop_clr, then start, then key_valid.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    beep_d  = '0;
    case (state_q)
      IDLE: begin
        if (stop_clr) begin
          entry_d = 16'h0000;
        end else if (start) begin
          state_d = IDLE;
        end else if (key_ok) begin
          entry_d = entry_shift;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_clr) begin
          entry_d = 16'h0000;
          state_d = IDLE;
        end else if (start) begin
          if (start_ok) state_d = LOAD;
        end else if (key_ok) begin
          entry_d = entry_shift;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (stop_clr)          state_d = PAUSE;
        else if (all_zero)     state_d = DONE;
        else if (!door_closed) state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_clr) begin
          entry_d = 16'h0000;
          state_d = IDLE;
        end else if (start && door_closed) begin
          state_d = RUN;
        end
      end
      DONE: begin
        beep_d = beep_q;
        if (stop_clr) begin
          entry_d = 16'h0000;
          beep_d  = '0;
          state_d = IDLE;
        end else if (tick_1hz) begin
          if (beep_q == BEEP_LAST) begin
            entry_d = 16'h0000;
            beep_d  = '0;
            state_d = IDLE;
          end else begin
            beep_d = beep_q + 1'b1;
          end
        end
      end
      default: begin
        entry_d = 16'h0000;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from the registered state only, so reset forces them immediately.
  assign load_n    = (state_q != LOAD);
  assign load_data = entry_q;
  assign count_en  = (state_q == RUN) && tick_1hz && door_closed && !all_zero;
  assign mag_on    = (state_q == RUN) && door_closed;
  assign done_beep = (state_q == DONE);
  assign state     = state_q;

endmodule
